// File: rtl/spi_wb_sequencer.sv
// Wishbone master that runs a CS-held SPI burst against the SPI master's
// register port: CONFIG write, then per byte a DATA write, DATA polling until
// not busy and an RX push, then a closing CONFIG write.
`timescale 1ns/1ps
module spi_wb_sequencer #(
  parameter logic [31:0] BASE_ADR    = 32'h2400_0000,
  parameter logic [31:0] CFG_OFS     = 32'h0000_0000,
  parameter logic [31:0] DATA_OFS    = 32'h0000_0004,
  parameter logic [31:0] CFG_WORD    = 32'h0000_A002,
  parameter logic [31:0] STREAM_MASK = 32'h0000_1000,
  parameter logic [31:0] BUSY_MASK   = 32'h0000_0100,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_len,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        done,
  output logic        err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_WR, S_WAIT_TX, S_DATA_WR, S_POLL, S_RX_PUSH, S_CFG_END, S_DONE
  } state_t;

  localparam logic [31:0] CFG_ADR  = BASE_ADR | CFG_OFS;
  localparam logic [31:0] DATA_ADR = BASE_ADR | DATA_OFS;

  state_t      state_q, state_n;
  logic        cyc_q, we_q;
  logic [31:0] adr_q, dat_q;
  logic [7:0]  tmo_q;
  logic [8:0]  rem_q, rem_n;
  logic [7:0]  tx_q, rx_q;
  logic        err_q;

  logic        ack_evt, tmo_evt, start, err_set, err_clr, tx_lat, rx_lat;
  logic        bus_we;
  logic [31:0] bus_adr, bus_dat;

  // Next-state decode; bus states (re)launch their cycle whenever the bus is
  // idle, which gives the mandatory idle cycle between back-to-back cycles.
  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    start   = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    tx_lat  = 1'b0;
    rx_lat  = 1'b0;
    ack_evt = cyc_q & wbm_ack_i;
    tmo_evt = cyc_q & ~wbm_ack_i & (tmo_q == ACK_TIMEOUT - 8'd1);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_n = S_CFG_WR;
          start   = 1'b1;
          err_clr = 1'b1;
          rem_n   = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
        end
      end
      S_WAIT_TX: begin
        if (tx_valid) begin
          tx_lat  = 1'b1;
          state_n = S_DATA_WR;
          start   = 1'b1;
        end
      end
      S_RX_PUSH: begin
        if (rx_ready) begin
          rem_n = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_n = S_CFG_END;
            start   = 1'b1;
          end else begin
            state_n = S_WAIT_TX;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        if (ack_evt) begin
          case (state_q)
            S_CFG_WR:  state_n = S_WAIT_TX;
            S_DATA_WR: state_n = S_POLL;
            S_POLL: begin
              if ((wbm_dat_i & BUSY_MASK) == 32'd0) begin
                rx_lat  = 1'b1;
                state_n = S_RX_PUSH;
              end
            end
            default:   state_n = S_DONE;
          endcase
        end else if (tmo_evt) begin
          err_set = 1'b1;
          state_n = (state_q == S_CFG_END) ? S_DONE : S_CFG_END;
        end else if (!cyc_q) begin
          start = 1'b1;
        end
      end
    endcase
  end

  // Address/data/direction for the cycle about to be launched.
  always_comb begin
    bus_we  = 1'b0;
    bus_adr = 32'd0;
    bus_dat = 32'd0;
    case (state_n)
      S_CFG_WR: begin
        bus_we  = 1'b1;
        bus_adr = CFG_ADR;
        bus_dat = CFG_WORD | STREAM_MASK;
      end
      S_DATA_WR: begin
        bus_we  = 1'b1;
        bus_adr = DATA_ADR;
        bus_dat = {24'd0, (tx_lat ? tx_data : tx_q)};
      end
      S_POLL: bus_adr = DATA_ADR;
      S_CFG_END: begin
        bus_we  = 1'b1;
        bus_adr = CFG_ADR;
        bus_dat = CFG_WORD & ~STREAM_MASK;
      end
      default: ;
    endcase
  end

  // State, counters, latched bytes and the registered Wishbone cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      rem_q   <= 9'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      if (tx_lat) tx_q <= tx_data;
      if (rx_lat) rx_q <= wbm_dat_i[7:0];
      if (err_clr)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
      if (start) begin
        cyc_q <= 1'b1;
        we_q  <= bus_we;
        adr_q <= bus_adr;
        dat_q <= bus_dat;
        tmo_q <= 8'd0;
      end else if (ack_evt || tmo_evt) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
        adr_q <= 32'd0;
        dat_q <= 32'd0;
        tmo_q <= 8'd0;
      end else if (cyc_q) begin
        tmo_q <= tmo_q + 8'd1;
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE) & ~wb_rst_i;
  assign tx_ready  = (state_q == S_WAIT_TX) & tx_valid;
  assign rx_valid  = (state_q == S_RX_PUSH);
  assign rx_data   = rx_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Bench for spi_wb_sequencer: randomized bursts against a Wishbone slave
// model; the expected bus transaction list and RX stream are built from the
// burst description (byte count, TX bytes, busy polls per byte).
`timescale 1ns/1ps
module tb_spi_wb_sequencer;

  localparam logic [31:0] CFG_ADR  = 32'h2400_0000;
  localparam logic [31:0] DATA_ADR = 32'h2400_0004;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_len = 8'd0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [7:0]  tx_data = 8'd0;
  logic        rx_valid, rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        done, err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = 32'd0;

  spi_wb_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done), .err(err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model state
  int          busy_q[$];
  int          busy_left = 0;
  logic [64:0] act_bus[$];
  logic [7:0]  exp_rx[$];
  bit          noack_data = 0;
  bit          slow = 0;
  bit          in_cyc = 0;
  int          dly = 0;
  int          cyc_len = 0;
  int          last_tmo_len = -1;

  // Consumer / monitor state
  int          done_cnt = 0;
  int          rx_got = 0;
  int          hold_req = 0;
  int          hold_cnt = 0;
  logic [7:0]  hold_dat = 8'd0;
  bit          rx_always = 0;

  // Wishbone slave: logs each cycle at its start, acks after a short delay,
  // answers DATA reads with busy for the requested number of polls.
  initial begin
    logic [31:0] r;
    forever begin
      @(posedge clk); #1;
      if (wb_rst_i) begin
        wbm_ack_i = 1'b0; wbm_dat_i = 32'd0; in_cyc = 0;
      end else if (wbm_ack_i) begin
        wbm_ack_i = 1'b0; wbm_dat_i = 32'd0; in_cyc = 0;
        check("cyc_after_ack", wbm_cyc_o, 0);
      end else if (wbm_cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1; cyc_len = 0;
          dly = slow ? 20 : int'($urandom_range(0, 2));
          act_bus.push_back({wbm_we_o, wbm_adr_o, wbm_dat_o});
          check("sel", wbm_sel_o, 4'hF);
          check("stb", wbm_stb_o, 1);
          if (wbm_we_o && wbm_adr_o == DATA_ADR)
            busy_left = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
        end
        cyc_len++;
        if (noack_data && wbm_we_o && wbm_adr_o == DATA_ADR) begin
        end else if (dly > 0) begin
          dly--;
        end else begin
          wbm_ack_i = 1'b1;
          if (!wbm_we_o) begin
            r = $urandom;
            if (busy_left > 0) begin
              busy_left--;
              r[8] = 1'b1;
            end else begin
              r[8] = 1'b0;
              exp_rx.push_back(r[7:0]);
            end
            wbm_dat_i = r;
          end
        end
      end else if (in_cyc) begin
        in_cyc = 0; last_tmo_len = cyc_len;
      end
    end
  end

  // RX consumer and done monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (wb_rst_i) begin
        rx_ready = 1'b0; hold_cnt = 0;
      end else begin
        if (done) done_cnt++;
        if (rx_valid && hold_req > 0) begin
          hold_cnt = hold_req; hold_req = 0; hold_dat = rx_data;
        end
        if (hold_cnt > 0) begin
          rx_ready = 1'b0;
          hold_cnt--;
          check("hold_rx_valid", rx_valid, 1);
          check("hold_rx_data", rx_data, hold_dat);
          check("hold_no_bus", wbm_cyc_o, 0);
        end else begin
          rx_ready = rx_always ? 1'b1 : ($urandom_range(0, 2) != 0);
          if (rx_valid && rx_ready) begin
            if (exp_rx.size() == 0) check("rx_extra", 1, 0);
            else check("rx_data", rx_data, exp_rx.pop_front());
            rx_got++;
          end
        end
      end
    end
  end

  // One burst: builds the expected transaction list, drives the command and
  // TX bytes, then compares everything the slave and consumer observed.
  task automatic run_burst(input int n, input int gap, input int bmin, input int bmax, input bit noack);
    logic [7:0]  txb[$];
    logic [64:0] exp_bus[$];
    int nb, b, k, g;
    nb = noack ? 1 : n;
    busy_q.delete(); act_bus.delete(); exp_rx.delete();
    done_cnt = 0; rx_got = 0; last_tmo_len = -1; noack_data = noack;
    exp_bus.push_back({1'b1, CFG_ADR, 32'h0000_B002});
    for (int i = 0; i < nb; i++) begin
      txb.push_back(8'($urandom));
      b = int'($urandom_range(bmin, bmax));
      busy_q.push_back(b);
      exp_bus.push_back({1'b1, DATA_ADR, {24'd0, txb[i]}});
      if (!noack) for (int j = 0; j <= b; j++) exp_bus.push_back({1'b0, DATA_ADR, 32'd0});
    end
    exp_bus.push_back({1'b1, CFG_ADR, 32'h0000_A002});

    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'(n);
    #1 check("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    check("stb_latency", wbm_stb_o, 1);
    check("err_clear", err, 0);
    @(negedge clk);
    cmd_valid = 1'b0;

    for (int i = 0; i < nb; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) @(negedge clk);
      tx_valid = 1'b1; tx_data = txb[i];
      k = 0;
      #1;
      while (!tx_ready && k < 3000) begin @(negedge clk); #1; k++; end
      if (k >= 3000) begin check("tx_wait", 0, 1); break; end
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
    end

    k = 0;
    while (done_cnt == 0 && k < 20000) begin @(negedge clk); k++; end
    check("done_seen", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("bus_count", act_bus.size(), exp_bus.size());
    for (int i = 0; i < exp_bus.size() && i < act_bus.size(); i++)
      check($sformatf("bus%0d", i), act_bus[i], exp_bus[i]);
    check("rx_count", rx_got, noack ? 0 : n);
    check("rx_pending", exp_rx.size(), 0);
    if (noack) begin
      check("err_set", err, 1);
      check("tmo_len", last_tmo_len, 255);
    end else begin
      check("err_idle", err, 0);
    end
    noack_data = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_bus", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_done_err", {done, err, tx_ready}, 0);
    wb_rst_i = 1'b0;
    #1 check("cmd_ready_after_rst", cmd_ready, 1);

    // Single byte, three busy polls
    run_burst(1, 0, 3, 3, 0);
    // Three bytes with gapped TX
    run_burst(3, 5, 0, 2, 0);
    // RX consumer stalls for 10 cycles
    hold_req = 10;
    run_burst(1, 0, 0, 1, 0);
    // Random bursts
    for (int i = 0; i < 4; i++) run_burst(int'($urandom_range(1, 6)), -1, 0, 2, 0);
    // Slave never acks the DATA write; next command clears err
    run_burst(1, 0, 0, 0, 1);
    run_burst(2, 1, 0, 1, 0);

    // Reset in the middle of a POLL cycle
    busy_q.delete(); slow = 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0; tx_valid = 1'b1; tx_data = 8'h33;
    k = 0;
    #1;
    while (!tx_ready && k < 3000) begin @(negedge clk); #1; k++; end
    check("r5_tx_wait", k < 3000, 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    k = 0;
    while (!(wbm_cyc_o && !wbm_we_o) && k < 3000) begin @(negedge clk); k++; end
    check("r5_poll_seen", k < 3000, 1);
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    check("r5_cyc", wbm_cyc_o, 0);
    check("r5_stb", wbm_stb_o, 0);
    check("r5_rx_valid", rx_valid, 0);
    @(negedge clk);
    wb_rst_i = 1'b0; slow = 0;
    #1 check("r5_cmd_ready", cmd_ready, 1);
    exp_rx.delete();
    run_burst(2, 0, 0, 1, 0);

    // 256-byte burst
    rx_always = 1;
    run_burst(256, 0, 0, 1, 0);
    rx_always = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
